snn_infer_sched: RTL

//  Top-level sequencer for one SNN inference. Receives a 784-pixel bitmap as 98 UART bytes
//  and unpacks it into the 1-bit input-unit RAM. Then hands RAM read access to snn_core and

---
 rtl/snn_pkg.sv | 16 +
 rtl/snn_pix_unpack.sv | 32 +++
 rtl/snn_infer_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared state encoding and byte constants for the SNN inference scheduler.
package snn_pkg;

    typedef enum logic [2:0] {
        LOAD,
        UNPACK,
        START,
        INFER,
        TX,
        WAIT_TX
    } sched_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ERR_BYTE   = 8'hFF;

endpackage

// File: rtl/snn_pix_unpack.sv
// Byte-to-pixel unpacker: loads one UART byte and shifts it out LSB first.
// last flags the eighth bit of the byte currently being shifted.
module snn_pix_unpack (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] data_i,
    output logic       bit_o,
    output logic       last
);

    logic [7:0] shreg_q;
    logic [2:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
        end else if (shift) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
            cnt_q   <= cnt_q + 3'd1;
        end
    end

    assign bit_o = shreg_q[0];
    assign last  = (cnt_q == 3'd7);

endmodule

// File: rtl/snn_infer_sched.sv
// Sequencer for one SNN inference: UART bitmap -> input RAM -> snn_core -> UART digit.
// Optional inference watchdog enabled by defining SNN_SCHED_TIMEOUT_EN.
module snn_infer_sched
    import snn_pkg::*;
#(
    parameter int NUM_PIXELS  = 784,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_clr_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    output logic              ram_we,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic [3:0]        digit,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_PIXELS - 1);

    // The watchdog counter is 16 bits wide; an empty named block marks a bad limit.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_timeout_cfg_invalid
    end

    sched_state_t      state_q;
    logic [ADDR_W-1:0] pix_ptr_q;
    logic              rx_clr_q;
    logic              core_start_q;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic [3:0]        digit_q;
    logic              pix_bit;
    logic              pix_last;
    logic              unpack_load;
    logic              unpack_shift;

`ifdef SNN_SCHED_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wdog_q;
`endif

    assign unpack_load  = (state_q == LOAD) && rx_rdy;
    assign unpack_shift = (state_q == UNPACK);

    snn_pix_unpack u_unpack (
        .clk    (clk),
        .rst    (rst),
        .load   (unpack_load),
        .shift  (unpack_shift),
        .data_i (rx_data),
        .bit_o  (pix_bit),
        .last   (pix_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            pix_ptr_q    <= '0;
            rx_clr_q     <= 1'b0;
            core_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            digit_q      <= '0;
`ifdef SNN_SCHED_TIMEOUT_EN
            wdog_q       <= '0;
`endif
        end else begin
            rx_clr_q     <= 1'b0;
            core_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (rx_rdy) begin
                        rx_clr_q <= 1'b1;
                        state_q  <= UNPACK;
                    end
                end
                UNPACK: begin
                    pix_ptr_q <= pix_ptr_q + ADDR_W'(1);
                    if (pix_last) begin
                        // Post-increment pointer reaching NUM_PIXELS closes the frame.
                        if (pix_ptr_q == LAST_PTR) begin
                            core_start_q <= 1'b1;
                            state_q      <= START;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                START: begin
                    pix_ptr_q <= '0;
`ifdef SNN_SCHED_TIMEOUT_EN
                    wdog_q    <= '0;
`endif
                    state_q   <= INFER;
                end
                INFER: begin
                    if (core_done) begin
                        digit_q    <= core_digit;
                        tx_data_q  <= ASCII_ZERO + {4'b0000, core_digit};
                        tx_start_q <= 1'b1;
                        state_q    <= TX;
                    end
`ifdef SNN_SCHED_TIMEOUT_EN
                    else if (wdog_q == WDOG_LIMIT) begin
                        tx_data_q  <= ERR_BYTE;
                        tx_start_q <= 1'b1;
                        state_q    <= TX;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
`endif
                end
                TX: begin
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) state_q <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // During INFER the core owns the read address; RAM latency is the core's concern.
    assign ram_addr   = (state_q == INFER) ? core_addr : pix_ptr_q;
    assign ram_we     = (state_q == UNPACK);
    assign ram_d      = ram_we & pix_bit;
    assign rx_clr_rdy = rx_clr_q;
    assign core_start = core_start_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign digit      = digit_q;
    assign busy       = (state_q != LOAD);

endmodule
